// File: rtl/serial_adder_if.sv
// ---------------------------------------------------------------------------
// serial_adder_if
// Bundles the request/result handshake of the bit-serial adder/subtractor.
//
// Signals:
//   Start    request, sampled by the adder only while it is not working
//   A, B     operands (WIDTH bits), captured on an accepted Start
//   Cin      carry-in for add, ignored when Sub=1
//   Sub      1 = compute A - B
//   Acc      (only with SERIAL_ADDER_ACCUM_EN) take operand A from Sum
//   Busy     high while operand bits are being processed
//   Done     one-cycle pulse when the result is valid
//   Sum      result (WIDTH bits), held until the next accepted Start
//   Cout     final carry-out (for Sub, 1 = no borrow)
//   Overflow signed overflow
//
// Modports: master drives the request side, slave is the adder itself.
// Optional macro: SERIAL_ADDER_ACCUM_EN adds the Acc request bit.
// ---------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
`ifdef SERIAL_ADDER_ACCUM_EN
  logic             Acc;
`endif
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Overflow;

  modport master (
`ifdef SERIAL_ADDER_ACCUM_EN
    output Acc,
`endif
    output Start, A, B, Cin, Sub,
    input  Busy, Done, Sum, Cout, Overflow
  );

  modport slave (
`ifdef SERIAL_ADDER_ACCUM_EN
    input  Acc,
`endif
    input  Start, A, B, Cin, Sub,
    output Busy, Done, Sum, Cout, Overflow
  );
endinterface

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Bit-serial adder/subtractor: one full-adder slice plus a carry flip-flop,
// one operand bit per clock, LSB first. Subtraction is A + ~B + 1.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (overrides Start)
//   bus   serial_adder_if.slave : Start/A/B/Cin/Sub[/Acc] in,
//                                 Busy/Done/Sum/Cout/Overflow out
//
// Timing: Start accepted at edge k -> Busy high after edges k+1..k+WIDTH ->
// Done high (Busy low) for one cycle after edge k+WIDTH+1.
//
// Optional macro: SERIAL_ADDER_ACCUM_EN. When defined, bus.Acc=1 on an
// accepted Start loads operand A from the current Sum register.
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_lastBit;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_opA;
  logic [WIDTH-1:0] w_opB;

  // Start is only honoured when no operation is in flight; the Done cycle
  // counts as idle so back-to-back operations lose no cycle.
  assign w_accept  = bus.Start && ((r_state == IDLE) || (r_state == DONE));
  assign w_lastBit = (r_cnt == CNT_W'(WIDTH - 1));

  // Single full-adder slice working on the LSBs of the shift registers.
  assign w_s = r_sa[0] ^ r_sb[0] ^ r_carry;
  assign w_c = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);

`ifdef SERIAL_ADDER_ACCUM_EN
  assign w_opA = bus.Acc ? r_sum : bus.A;
`else
  assign w_opA = bus.A;
`endif
  assign w_opB = bus.Sub ? ~bus.B : bus.B;

  // Control and datapath in one registered FSM. The first RUN cycle only
  // raises Busy; bits are processed on the following WIDTH edges, the last
  // of which also latches Cout/Overflow and moves to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_sa    <= w_opA;
            r_sb    <= w_opB;
            // subtract needs the +1 of the two's complement as carry-in
            r_carry <= bus.Sub | bus.Cin;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end

        RUN: begin
          if (!r_busy) begin
            r_busy <= 1'b1;
          end else begin
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_carry <= w_c;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_lastBit) begin
              // r_carry is still the carry into the MSB here
              r_cout  <= w_c;
              r_ovf   <= r_carry ^ w_c;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy     = r_busy;
  assign bus.Done     = r_done;
  assign bus.Sum      = r_sum;
  assign bus.Cout     = r_cout;
  assign bus.Overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH=8): directed cases followed by
// random operations, all compared against a plain-arithmetic reference.
// Optional macro: SERIAL_ADDER_ACCUM_EN enables the accumulate cases.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   assertCount = 0;
  int   failCount   = 0;
  logic [WIDTH-1:0] modelSum = '0;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive a request and hold Start through exactly one accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic sub, input logic acc);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    bus.Sub   = sub;
`ifdef SERIAL_ADDER_ACCUM_EN
    bus.Acc   = acc;
`endif
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
  endtask

  // Count edges after acceptance until Done (bounded). At cycle injectAt
  // a stray Start (kind 1) or a reset (kind 2) is applied for one edge.
  task automatic waitDone(input int injectAt, input int kind,
                          output int cycles, output logic sawDone);
    logic pend;
    pend    = 1'b0;
    cycles  = 0;
    sawDone = 1'b0;
    while (!sawDone && cycles < 4 * WIDTH) begin
      @(posedge clk);
      #1;
      cycles++;
      if (pend) begin
        bus.Start = 1'b0;
        rst       = 1'b0;
        pend      = 1'b0;
      end
      if (bus.Done === 1'b1) begin
        sawDone = 1'b1;
      end else if (cycles == injectAt) begin
        if (kind == 1) begin
          bus.A     = 8'hAA;
          bus.Start = 1'b1;
        end else if (kind == 2) begin
          rst = 1'b1;
        end
        pend = 1'b1;
      end
    end
  endtask

  // Full operation with reference-model checks of latency and results.
  task automatic runOp(input string tag, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic cin,
                       input logic sub, input logic acc, input int injectAt,
                       input int kind);
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH:0]   full;
    logic             expOvf;
    int               cycles;
    logic             sawDone;
    opA  = acc ? modelSum : a;
    opB  = sub ? ~b : b;
    full = {1'b0, opA} + {1'b0, opB} + (WIDTH + 1)'(sub | cin);
    expOvf = (opA[WIDTH-1] == opB[WIDTH-1]) && (full[WIDTH-1] != opA[WIDTH-1]);
    applyStimulus(a, b, cin, sub, acc);
    waitDone(injectAt, kind, cycles, sawDone);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(WIDTH + 1));
    checkOutput({tag, "_busyAtDone"}, 32'(bus.Busy), 32'(0));
    checkOutput({tag, "_sum"}, 32'(bus.Sum), 32'(full[WIDTH-1:0]));
    checkOutput({tag, "_cout"}, 32'(bus.Cout), 32'(full[WIDTH]));
    checkOutput({tag, "_ovf"}, 32'(bus.Overflow), 32'(expOvf));
    modelSum = full[WIDTH-1:0];
  endtask

  initial begin
    int         gap;
    int         cycles;
    logic       sawDone;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    bus.Start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;
    bus.Sub   = 1'b0;
`ifdef SERIAL_ADDER_ACCUM_EN
    bus.Acc   = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(bus.Busy), 32'(0));
    checkOutput("reset_done", 32'(bus.Done), 32'(0));
    checkOutput("reset_sum", 32'(bus.Sum), 32'(0));
    checkOutput("reset_cout", 32'(bus.Cout), 32'(0));
    checkOutput("reset_ovf", 32'(bus.Overflow), 32'(0));

    $display("[TB] directed add/sub cases");
    runOp("add5A33", 8'h5A, 8'h33, 1'b1, 1'b0, 1'b0, -1, 0);
    checkOutput("add5A33_const", {bus.Overflow, bus.Cout, bus.Sum}, {22'd0, 1'b1, 1'b0, 8'h8E});
    repeat (2) @(posedge clk);
    runOp("wrapFF01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, -1, 0);
    checkOutput("wrapFF01_const", {bus.Overflow, bus.Cout, bus.Sum}, {22'd0, 1'b0, 1'b1, 8'h00});
    runOp("b2b7F01", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, -1, 0);
    checkOutput("b2b7F01_const", {bus.Overflow, bus.Cout, bus.Sum}, {22'd0, 1'b1, 1'b0, 8'h80});
    repeat (1) @(posedge clk);
    runOp("sub1020", 8'h10, 8'h20, 1'b1, 1'b1, 1'b0, -1, 0);
    checkOutput("sub1020_const", {bus.Overflow, bus.Cout, bus.Sum}, {22'd0, 1'b0, 1'b0, 8'hF0});
    runOp("sub8001", 8'h80, 8'h01, 1'b0, 1'b1, 1'b0, -1, 0);
    checkOutput("sub8001_const", {bus.Overflow, bus.Cout, bus.Sum}, {22'd0, 1'b1, 1'b1, 8'h7F});

    $display("[TB] protocol: Start while busy, reset while busy");
    repeat (2) @(posedge clk);
    runOp("ignoreStart", 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 3, 1);
    checkOutput("ignoreStart_const", 32'(bus.Sum), 32'(8'h10));
    repeat (2) @(posedge clk);
    applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
    waitDone(3, 2, cycles, sawDone);
    checkOutput("abort_noDone", 32'(sawDone), 32'(0));
    checkOutput("abort_outputs", {bus.Busy, bus.Done, bus.Cout, bus.Overflow, bus.Sum}, 32'(0));
    modelSum = '0;
    runOp("afterAbort", 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, -1, 0);
    checkOutput("afterAbort_const", 32'(bus.Sum), 32'(8'h05));

`ifdef SERIAL_ADDER_ACCUM_EN
    $display("[TB] accumulate cases");
    runOp("accSeed", 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, -1, 0);
    runOp("acc1", 8'hEE, 8'h07, 1'b0, 1'b0, 1'b1, -1, 0);
    checkOutput("acc1_const", 32'(bus.Sum), 32'(8'h0C));
    runOp("acc2", 8'hEE, 8'h07, 1'b0, 1'b0, 1'b1, -1, 0);
    checkOutput("acc2_const", 32'(bus.Sum), 32'(8'h13));
    runOp("acc3", 8'hEE, 8'h07, 1'b0, 1'b0, 1'b1, -1, 0);
    checkOutput("acc3_const", 32'(bus.Sum), 32'(8'h1A));
`endif

    $display("[TB] random operations");
    for (int i = 0; i < 30; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
`ifdef SERIAL_ADDER_ACCUM_EN
      runOp($sformatf("rnd%0d", i), ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), -1, 0);
`else
      runOp($sformatf("rnd%0d", i), ra, rb, 1'($urandom), 1'($urandom), 1'b0, -1, 0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor built around a single full-adder slice and a carry flip-flop.
- Processes one operand bit per clock, LSB first, under a Start/Busy/Done handshake.
- Successor to the combinational 1-bit full adder. Trades latency for area in multi-bit arithmetic datapaths of the lab designs.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not to be overridden)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous active-high reset
Start  input  1  request; sampled only when not Busy
A  input  WIDTH  operand A, captured on accepted Start
B  input  WIDTH  operand B, captured on accepted Start
Cin  input  1  carry-in for add; ignored when Sub=1
Sub  input  1  captured on Start; 1 = compute A - B
Busy  output  1  high while bits are being processed
Done  output  1  one-cycle pulse when result valid
Sum  output  WIDTH  result register; held until next accepted Start
Cout  output  1  final carry-out (Sub: 1 = no borrow)
Overflow  output  1  signed overflow = carry into MSB XOR Cout

Behaviour:
- Reset: synchronous on rst=1 at a clk edge. Busy=0, Done=0, Sum=0, Cout=0, Overflow=0, internal shift registers, carry FF and counter all cleared. Reset overrides Start.
- FSM states:
  - IDLE: Start=1 -> RUN. Latches A into shift register SA and B^{WIDTH{Sub}} into SB. Carry FF = Sub ? 1 : Cin. Counter = 0. Sum cleared.
  - RUN: each cycle the full-adder slice computes s = SA[0]^SB[0]^c and c' = majority(SA[0], SB[0], c). s shifts into Sum MSB (Sum right-shifts), SA/SB right-shift, c <= c', counter increments. Before the last bit updates the carry FF, the carry entering the last bit is saved for Overflow.
  - RUN -> DONE when counter reaches WIDTH-1 and that bit is processed.
  - DONE: Done=1 for exactly one cycle. Cout = final carry, Overflow = carry into MSB XOR Cout. Next state is IDLE; a Start sampled in DONE is accepted identically to IDLE.
- Latency: Start sampled at edge k -> Busy=1 after edges k+1..k+WIDTH -> Done=1 and Busy=0 after edge k+WIDTH+1. Total WIDTH+1 cycles from acceptance to Done.
- Start while Busy=1 is ignored (no capture, no effect on the in-flight operation).
- Sum, Cout and Overflow are stable and valid from Done until the next accepted Start. Sum bits are not meaningful while Busy=1.
- Arithmetic is modulo 2^WIDTH. Sub computes A + ~B + 1.
- Reset during RUN aborts the operation with no Done pulse and all outputs are cleared. A Start on the first non-reset edge is accepted normally.
- Busy and Done are never high in the same cycle.

Optional Feature:
SERIAL_ADDER_ACCUM_EN
- Defined: adds input port Acc (1 bit).
  - Acc=1 on an accepted Start: SA is loaded from the current Sum register instead of A. This supports running sums such as Sum <= Sum + B + Cin, or Sum - B.
  - Acc=0: behaviour identical to the base block.
- Not defined: no Acc port, and A is always the operand. Every other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles, then idle -> Busy=0, Done=0, Sum=8'h00, Cout=0, Overflow=0.
- Add (WIDTH=8): A=8'h5A, B=8'h33, Cin=1, Sub=0, Start pulse -> Done 9 cycles after Start; Sum=8'h8E, Cout=0, Overflow=1.
- Carry wrap: A=8'hFF, B=8'h01, Cin=0 -> Sum=8'h00, Cout=1, Overflow=0. Back-to-back Start in the Done cycle with A=8'h7F, B=8'h01 -> Sum=8'h80, Overflow=1.
- Subtract:
  - A=8'h10, B=8'h20, Sub=1 -> Sum=8'hF0, Cout=0, Overflow=0.
  - A=8'h80, B=8'h01, Sub=1 -> Sum=8'h7F, Cout=1, Overflow=1.
- Protocol: start A=8'h0F+B=8'h01. At the 3rd Busy cycle pulse Start with A=8'hAA -> ignored; result Sum=8'h10. Repeat and assert rst at the 3rd Busy cycle -> no Done, all outputs 0; the next Start with 8'h02+8'h03 gives Sum=8'h05.
- With SERIAL_ADDER_ACCUM_EN: add 8'h05+8'h00, then Acc=1 with B=8'h07 three times -> Sum sequence 8'h0C, 8'h13, 8'h1A.
